// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice resolved per stage,
// elastic valid/ready flow with full throughput and backpressure.
module pipelined_csel_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    generate
        if (WIDTH % BLOCK != 0) begin : g_param_err
            $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
        end
    endgenerate

    logic             r_vld [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic             r_ovf;

    logic             w_rdy  [STAGES+1];
    logic             w_vin  [STAGES];
    logic             w_cin  [STAGES];
    logic [WIDTH-1:0] w_opa  [STAGES];
    logic [WIDTH-1:0] w_opb  [STAGES];
    logic [WIDTH-1:0] w_psum [STAGES];
    logic [WIDTH-1:0] w_nsum [STAGES];
    logic             w_nc   [STAGES];
    logic [BLOCK:0]   w_s0;
    logic [BLOCK:0]   w_s1;
    logic [BLOCK:0]   w_sel;
    logic             w_novf;

    always_comb begin
        w_rdy[STAGES] = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            w_rdy[k] = !r_vld[k] || w_rdy[k+1];
        end

        // Stage 0 takes operands straight from the port; B is pre-inverted for subtract.
        w_vin[0]  = in_valid;
        w_cin[0]  = Sub | Cin;
        w_opa[0]  = A;
        w_opb[0]  = B ^ {WIDTH{Sub}};
        w_psum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k]  = r_vld[k-1];
            w_cin[k]  = r_c[k-1];
            w_opa[k]  = r_a[k-1];
            w_opb[k]  = r_b[k-1];
            w_psum[k] = r_sum[k-1];
        end

        w_s0  = '0;
        w_s1  = '0;
        w_sel = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_s0  = {1'b0, w_opa[k][BLOCK*k +: BLOCK]} + {1'b0, w_opb[k][BLOCK*k +: BLOCK]};
            w_s1  = {1'b0, w_opa[k][BLOCK*k +: BLOCK]} + {1'b0, w_opb[k][BLOCK*k +: BLOCK]}
                    + (BLOCK+1)'(1);
            w_sel = w_cin[k] ? w_s1 : w_s0;
            w_nsum[k] = w_psum[k];
            w_nsum[k][BLOCK*k +: BLOCK] = w_sel[BLOCK-1:0];
            w_nc[k] = w_sel[BLOCK];
        end

        // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
        w_novf = (w_nsum[LAST][WIDTH-1] ^ w_opa[LAST][WIDTH-1] ^ w_opb[LAST][WIDTH-1])
                 ^ w_nc[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_c[k]   <= 1'b0;
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
            r_ovf <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_sum[k] <= w_nsum[k];
                        r_c[k]   <= w_nc[k];
                        r_a[k]   <= w_opa[k];
                        r_b[k]   <= w_opb[k];
                    end
                end
            end
            if (w_rdy[LAST] && w_vin[LAST]) begin
                r_ovf <= w_novf;
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_vld[LAST];
    assign Sum       = r_sum[LAST];
    assign Cout      = r_c[LAST];
    assign Ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: three instances (BLOCK 8/32/4) share one stimulus
// stream and are scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_csel_adder;
    localparam int W  = 32;
    localparam int ND = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           cin_i;
    logic           sub_i;
    logic           out_ready;
    logic [ND-1:0]  en;
    logic [ND-1:0]  irdy;
    logic [ND-1:0]  ovld;
    logic [ND-1:0]  cout_o;
    logic [ND-1:0]  ovf_o;
    logic [ND-1:0]  v_in;
    logic [W-1:0]   sum_o [ND];
    logic           gate;

    int vectors     = 0;
    int miscompares = 0;

    logic [W+1:0]   exp_q [ND][$];
    logic [ND-1:0]  prev_stall;
    logic [W+1:0]   prev_out [ND];

    always #5 clk = ~clk;

    // All enabled instances accept on the same edge so their streams stay identical.
    assign gate = &(irdy | ~en);
    assign v_in = {ND{in_valid & gate}} & en;

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) u_b8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in[0]), .in_ready(irdy[0]),
        .A(a_i), .B(b_i), .Cin(cin_i), .Sub(sub_i),
        .out_valid(ovld[0]), .out_ready(out_ready),
        .Sum(sum_o[0]), .Cout(cout_o[0]), .Ovf(ovf_o[0])
    );

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(32)) u_b32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in[1]), .in_ready(irdy[1]),
        .A(a_i), .B(b_i), .Cin(cin_i), .Sub(sub_i),
        .out_valid(ovld[1]), .out_ready(out_ready),
        .Sum(sum_o[1]), .Cout(cout_o[1]), .Ovf(ovf_o[1])
    );

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in[2]), .in_ready(irdy[2]),
        .A(a_i), .B(b_i), .Cin(cin_i), .Sub(sub_i),
        .out_valid(ovld[2]), .out_ready(out_ready),
        .Sum(sum_o[2]), .Cout(cout_o[2]), .Ovf(ovf_o[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Reference: plain modulo arithmetic, overflow from operand/result signs. Layout {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] bo;
        logic [W:0]   r;
        logic         ov;
        bo = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, (s ? 1'b1 : c)};
        ov = (a[W-1] == bo[W-1]) && (r[W-1] != a[W-1]);
        return {ov, r};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Scoreboard: records accepted beats, checks every released result and output stability.
    initial begin
        prev_stall = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!rst_n) begin
                    exp_q[d].delete();
                    prev_stall[d] = 1'b0;
                end else begin
                    if (prev_stall[d]) begin
                        chk("hold", d, 64'({ovld[d], ovf_o[d], cout_o[d], sum_o[d]}),
                            64'({1'b1, prev_out[d]}));
                    end
                    if (ovld[d] && out_ready) begin
                        if (exp_q[d].size() == 0) begin
                            chk("spurious", d, 64'(ovld[d]), 64'(0));
                        end else begin
                            chk("result", d, 64'({ovf_o[d], cout_o[d], sum_o[d]}),
                                64'(exp_q[d].pop_front()));
                        end
                    end
                    prev_stall[d] = ovld[d] && !out_ready;
                    prev_out[d]   = {ovf_o[d], cout_o[d], sum_o[d]};
                    if (v_in[d] && irdy[d]) begin
                        exp_q[d].push_back(model(a_i, b_i, cin_i, sub_i));
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, output int waited);
        waited = 0;
        a_i = a; b_i = b; cin_i = c; sub_i = s; in_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!gate && waited < 200);
        if (!gate) chk("accept_timeout", 0, 64'(gate), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic lit(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s,
                       input logic [W-1:0] es, input logic ec, input logic eo);
        logic [ND-1:0] seen;
        int w;
        seen = '0;
        send(a, b, c, s, w);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!seen[d] && ovld[d]) begin
                    seen[d] = 1'b1;
                    chk("latency", d, 64'(n), 64'(lat_of(d)));
                    chk("lit_sum", d, 64'(sum_o[d]), 64'(es));
                    chk("lit_cout", d, 64'(cout_o[d]), 64'(ec));
                    chk("lit_ovf", d, 64'(ovf_o[d]), 64'(eo));
                end
            end
        end
        for (int d = 0; d < ND; d++) chk("lit_seen", d, 64'(seen[d]), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 0, 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  w;
        bit  run_tog;
        rst_n = 1'b0; in_valid = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        out_ready = 1'b1; en = '1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset release
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                chk("idle_ovld", d, 64'(ovld[d]), 64'(0));
                chk("idle_irdy", d, 64'(irdy[d]), 64'(1));
                chk("idle_sum", d, 64'(sum_o[d]), 64'(0));
            end
        end
        @(posedge clk);
        #1;

        // Hand-computed boundary results
        lit(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        lit(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        lit(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        lit(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        lit(32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Random back-to-back stream with random backpressure
        run_tog = 1'b1;
        fork
            begin
                while (run_tog) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
                end
                run_tog = 1'b0;
            end
        join
        drain();

        // Fill BLOCK=8 instance under stall, then stream through it
        en = 3'b001;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, w);
        @(negedge clk);
        chk("full_irdy", 0, 64'(irdy[0]), 64'(0));
        chk("full_ovld", 0, 64'(ovld[0]), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
            chk("thru_wait", 0, 64'(w), 64'(1));
            chk("thru_ovld", 0, 64'(ovld[0]), 64'(1));
        end
        drain();
        en = '1;

        // Reset with operations in flight
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)), w);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) chk("rst_ovld", d, 64'(ovld[d]), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                chk("post_rst_ovld", d, 64'(ovld[d]), 64'(0));
                chk("post_rst_irdy", d, 64'(irdy[d]), 64'(1));
            end
        end
        @(posedge clk);
        #1;

        // Pipeline still works after the mid-stream reset
        lit(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
